// File: rtl/cgra_multi_context_loader.sv
// Multi-context CGRA configuration loader: fetches frames over req/ack into a non-active context
// and switches the active context by index. Optional trailer checksum: CGRA_CFG_CHECKSUM_EN.
module cgra_multi_context_loader #(
  parameter int unsigned NUM_PES      = 16,
  parameter int unsigned CONFIG_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned NUM_CTX      = 4,
  localparam int unsigned CTX_W       = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start_load,
  input  logic [CTX_W-1:0]                load_ctx,
  input  logic [ADDR_WIDTH-1:0]           bitstream_addr,
  input  logic [15:0]                     frame_count,
  output logic                            load_busy,
  output logic                            load_done,
  output logic                            load_error,
  output logic [2:0]                      err_code,
  input  logic                            activate,
  input  logic [CTX_W-1:0]                activate_ctx,
  output logic                            activate_reject,
  output logic [CTX_W-1:0]                active_ctx,
  output logic [NUM_CTX-1:0]              ctx_valid,
  output logic                            mem_req,
  output logic [ADDR_WIDTH-1:0]           mem_addr,
  input  logic                            mem_ack,
  input  logic [CONFIG_WIDTH-1:0]         mem_rdata,
  output logic [NUM_PES*CONFIG_WIDTH-1:0] config_flat,
  output logic                            config_valid
);

  localparam int unsigned PE_W = $clog2(NUM_PES);
  localparam logic [15:0] MaxFrames = 16'(NUM_PES);

  typedef enum logic [2:0] {
    StIdle, StClear, StFetch, StDone, StErr
`ifdef CGRA_CFG_CHECKSUM_EN
    , StCheck
`endif
  } state_e;

  state_e                  state_q, state_d;
  logic [NUM_CTX-1:0]      ctx_valid_q, ctx_valid_d;
  logic [CTX_W-1:0]        active_ctx_q, active_ctx_d;
  logic [CTX_W-1:0]        tgt_ctx_q, tgt_ctx_d;
  logic [2:0]              err_code_q, err_code_d;
  logic [15:0]             cnt_q, cnt_d;
  logic [PE_W-1:0]         idx_q, idx_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    reject_q, reject_d;
  logic [CONFIG_WIDTH-1:0] store_q [NUM_CTX][NUM_PES];
  logic [CONFIG_WIDTH-1:0] store_d [NUM_CTX][NUM_PES];
`ifdef CGRA_CFG_CHECKSUM_EN
  logic [CONFIG_WIDTH-1:0] csum_q, csum_d;
`endif

  logic loading, act_ok;

  // The target context stays locked from acceptance until the DONE cycle has passed.
  assign loading = (state_q != StIdle) && (state_q != StErr);
  assign act_ok  = (32'(activate_ctx) < NUM_CTX) && ctx_valid_q[activate_ctx] &&
                   !(loading && (activate_ctx == tgt_ctx_q));

  always_comb begin
    state_d      = state_q;
    ctx_valid_d  = ctx_valid_q;
    active_ctx_d = active_ctx_q;
    tgt_ctx_d    = tgt_ctx_q;
    err_code_d   = err_code_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    addr_d       = addr_q;
    reject_d     = 1'b0;
    store_d      = store_q;
`ifdef CGRA_CFG_CHECKSUM_EN
    csum_d       = csum_q;
`endif

    if (activate) begin
      if (act_ok) active_ctx_d = activate_ctx;
      else        reject_d     = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (start_load) begin
          // Validation compares against the pre-switch active context.
          if (frame_count == 16'd0 || frame_count > MaxFrames) begin
            err_code_d = 3'd1;
            state_d    = StErr;
          end else if (32'(load_ctx) >= NUM_CTX) begin
            err_code_d = 3'd2;
            state_d    = StErr;
          end else if (load_ctx == active_ctx_q) begin
            err_code_d = 3'd3;
            state_d    = StErr;
          end else begin
            err_code_d            = 3'd0;
            tgt_ctx_d             = load_ctx;
            cnt_d                 = frame_count;
            addr_d                = bitstream_addr;
            idx_d                 = '0;
            ctx_valid_d[load_ctx] = 1'b0;
`ifdef CGRA_CFG_CHECKSUM_EN
            csum_d                = '0;
`endif
            state_d               = StClear;
          end
        end
      end
      StClear: begin
        for (int p = 0; p < int'(NUM_PES); p++) store_d[tgt_ctx_q][p] = '0;
        state_d = StFetch;
      end
      StFetch: begin
        if (mem_ack) begin
          store_d[tgt_ctx_q][idx_q] = mem_rdata;
          addr_d                    = addr_q + 1'b1;
          idx_d                     = idx_q + 1'b1;
`ifdef CGRA_CFG_CHECKSUM_EN
          csum_d                    = csum_q ^ mem_rdata;
`endif
          if (16'(idx_q) + 16'd1 == cnt_q) begin
`ifdef CGRA_CFG_CHECKSUM_EN
            state_d = StCheck;
`else
            state_d = StDone;
`endif
          end
        end
      end
`ifdef CGRA_CFG_CHECKSUM_EN
      StCheck: begin
        if (mem_ack) begin
          if (mem_rdata == csum_q) begin
            state_d = StDone;
          end else begin
            err_code_d = 3'd4;
            state_d    = StErr;
          end
        end
      end
`endif
      StDone: begin
        ctx_valid_d[tgt_ctx_q] = 1'b1;
        state_d                = StIdle;
      end
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      ctx_valid_q  <= '0;
      active_ctx_q <= '0;
      tgt_ctx_q    <= '0;
      err_code_q   <= '0;
      cnt_q        <= '0;
      idx_q        <= '0;
      addr_q       <= '0;
      reject_q     <= 1'b0;
      store_q      <= '{default: '0};
`ifdef CGRA_CFG_CHECKSUM_EN
      csum_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      ctx_valid_q  <= ctx_valid_d;
      active_ctx_q <= active_ctx_d;
      tgt_ctx_q    <= tgt_ctx_d;
      err_code_q   <= err_code_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      addr_q       <= addr_d;
      reject_q     <= reject_d;
      store_q      <= store_d;
`ifdef CGRA_CFG_CHECKSUM_EN
      csum_q       <= csum_d;
`endif
    end
  end

  assign load_busy       = (state_q != StIdle);
  assign load_done       = (state_q == StDone);
  assign load_error      = (state_q == StErr);
  assign err_code        = err_code_q;
  assign activate_reject = reject_q;
  assign active_ctx      = active_ctx_q;
  assign ctx_valid       = ctx_valid_q;
`ifdef CGRA_CFG_CHECKSUM_EN
  assign mem_req         = (state_q == StFetch) || (state_q == StCheck);
`else
  assign mem_req         = (state_q == StFetch);
`endif
  assign mem_addr        = addr_q;
  assign config_valid    = ctx_valid_q[active_ctx_q];

  for (genvar p = 0; p < int'(NUM_PES); p++) begin : g_pe
    assign config_flat[p*CONFIG_WIDTH +: CONFIG_WIDTH] = store_q[active_ctx_q][p];
  end

endmodule

// File: doc/cgra_multi_context_loader.md
Name: cgra_multi_context_loader

Overview:
Parametrised successor to the CGRA double-buffered config loader. It holds NUM_CTX configuration contexts of NUM_PES frames each and fetches frames from memory over a req/ack handshake into any non-active context. It switches the active context atomically by index. It sits between the control unit and the PE array and drives the flattened per-PE configuration bus.

Parameters:
NUM_PES, 16, PEs per context (frames per full context); 2..64
CONFIG_WIDTH, 64, bits per PE configuration frame
ADDR_WIDTH, 32, memory word address width
NUM_CTX, 4, number of context banks; 2..16; CTX_W = max(1, clog2(NUM_CTX)) is a localparam

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
start_load  in  1  load request; sampled only when load_busy=0
load_ctx  in  CTX_W  target context index for the load
bitstream_addr  in  ADDR_WIDTH  word address of frame 0
frame_count  in  16  number of frames to load
load_busy  out  1  high from the cycle after a load is accepted until DONE/ERR completes
load_done  out  1  one-cycle pulse on successful completion
load_error  out  1  one-cycle pulse on rejected or failed load
err_code  out  3  reason for the last error; held until the next accepted start_load
activate  in  1  context switch request
activate_ctx  in  CTX_W  context to make active
activate_reject  out  1  one-cycle pulse when an activate request is refused
active_ctx  out  CTX_W  currently active context
ctx_valid  out  NUM_CTX  per-context "fully loaded" flags
mem_req  out  1  read request
mem_addr  out  ADDR_WIDTH  read address; stable while mem_req=1
mem_ack  in  1  read completes; mem_rdata valid this cycle
mem_rdata  in  CONFIG_WIDTH  read data
config_flat  out  NUM_PES*CONFIG_WIDTH  active context; PE i occupies bits [i*CONFIG_WIDTH +: CONFIG_WIDTH]
config_valid  out  1  equals ctx_valid[active_ctx]

Behaviour:
- Reset values: all storage 0, ctx_valid=0, active_ctx=0, err_code=0, all pulses 0, mem_req=0, mem_addr=0, load_busy=0. Reset mid-load aborts immediately with no partial state kept.
- FSM states: IDLE, CLEAR, FETCH, DONE, ERR, plus CHECK (optional feature only).
- IDLE + start_load: the request is validated first, in this priority order:
  - frame_count==0 or frame_count>NUM_PES gives err 1.
  - load_ctx>=NUM_CTX gives err 2.
  - load_ctx==active_ctx gives err 3.
  - On any failure: go to ERR, then load_error pulses the next cycle, then back to IDLE. No storage or flag changes.
- On acceptance: latch the address, count and context; clear ctx_valid[load_ctx]; go to CLEAR.
- CLEAR (1 cycle): zero all NUM_PES frames of the target context. Frames at or above frame_count remain zero.
- FETCH:
  - mem_req=1 with mem_addr = base + i.
  - On mem_ack, store mem_rdata into frame i, then increment i and mem_addr.
  - Only one request is outstanding. mem_req stays high across consecutive frames.
  - mem_req drops on the cycle after the last ack.
- DONE: set ctx_valid[load_ctx] and pulse load_done for 1 cycle, then IDLE. Zero-wait memory gives an N-frame load that is accepted at edge k and has load_done high in cycle k+N+2.
- start_load while load_busy=1 is ignored (no error).
- Activate is evaluated in every state. It is accepted iff activate_ctx<NUM_CTX, ctx_valid[activate_ctx]=1, and activate_ctx is not the context currently being loaded. When accepted, active_ctx updates at the next edge. Otherwise activate_reject pulses.
- Activate in the same cycle as DONE for that context is rejected, because ctx_valid is not yet set.
- Activate and start_load in the same cycle: activate wins. The load's active_ctx check uses the pre-switch value.
- The config_flat mux is combinational from registered storage; the switch is glitch-free at the edge.

Optional Feature:
CGRA_CFG_CHECKSUM_EN: when defined, after the last frame the block fetches one extra word at base+frame_count (state CHECK) and compares it with the XOR of all loaded frames.
- Match: DONE.
- Mismatch: err 4, load_error pulse, ctx_valid stays 0, and the frames remain written.

When the macro is undefined there is no CHECK state, no extra fetch, and err 4 is never produced.

Test Plan:
1. After reset, load ctx1 with frame_count=16 at addr 0x100, zero-wait ack, frame i=0xA000+i. Required: mem_addr runs 0x100..0x10F, load_done at k+18, ctx_valid=4'b0010, config_valid=0.
2. Activate ctx1 after test 1. Required: active_ctx=1 next cycle, config_flat PE5 = 0xA005, config_valid=1. Activate ctx2 (not loaded): activate_reject pulses, active_ctx stays 1.
3. Load ctx2 with frame_count=3 and random ack gaps of 0-4 cycles. Required: frames 0-2 correct, frames 3-15 = 0, mem_addr stable while waiting.
4. Error requests: start_load with frame_count=0 gives err 1; frame_count=17 gives err 1; load_ctx = active ctx gives err 3. Each gives a single load_error pulse and no ctx_valid change.
5. Assert rst in the middle of the fetch for ctx2 (frame 7). Required: all outputs return to reset values and ctx_valid=0. Separately, activate the ctx being loaded mid-load: activate_reject pulses.
6. With CGRA_CFG_CHECKSUM_EN defined: load 2 frames 0x1 and 0x3 with trailer 0x2. Required: load_done. Repeat with trailer 0x5. Required: err 4 and ctx_valid bit stays 0.
